// File: rtl/pulse_train_generator_if.sv
// Request-side bus of the pulse train generator.
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both 1. req_ready depends only on the generator's state,
// never on req_valid. The master must hold the request fields stable while
// req_valid is high and not yet accepted. abort is a plain level, sampled
// on every edge.
interface pulse_train_generator_if #(
    parameter int W_BITS = 8,
    parameter int C_BITS = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [W_BITS-1:0] req_width;
    logic [W_BITS-1:0] req_gap;
    logic [C_BITS-1:0] req_count;
    logic              abort;

    modport master (
        output req_valid, req_width, req_gap, req_count, abort,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_width, req_gap, req_count, abort,
        output req_ready
    );
endinterface

// File: rtl/pulse_train_generator.sv
// Pulse train generator: on an accepted request, drives `out` with
// req_count pulses of max(width,1) high cycles, separated by max(gap,1)
// low cycles. `done` strobes for one cycle on normal completion.
module pulse_train_generator #(
    parameter int W_BITS = 8,
    parameter int C_BITS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pulse_train_generator_if.slave  req,
    output logic                    out,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [W_BITS-1:0] phase_q, phase_d;
    logic [C_BITS-1:0] remain_q, remain_d;
    logic [W_BITS-1:0] width_q, width_d;
    logic [W_BITS-1:0] gap_q, gap_d;
    logic              out_q, out_d;
    logic              done_q, done_d;

    logic [W_BITS-1:0] w_eff;
    logic [W_BITS-1:0] g_eff;

    // Zero width/gap requests are promoted to one cycle.
    assign w_eff = (req.req_width == '0) ? W_BITS'(1) : req.req_width;
    assign g_eff = (req.req_gap == '0) ? W_BITS'(1) : req.req_gap;

    assign req.req_ready = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign out           = out_q;
    assign done          = done_q;
    assign dbg_state     = state_q;

    // Next-state logic; out_d is 1 exactly when the next state is HIGH.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        remain_d = remain_q;
        width_d  = width_q;
        gap_d    = gap_q;
        out_d    = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req.req_valid) begin
                    width_d = w_eff;
                    gap_d   = g_eff;
                    if (req.req_count != '0) begin
                        state_d  = S_HIGH;
                        phase_d  = w_eff - W_BITS'(1);
                        remain_d = req.req_count - C_BITS'(1);
                        out_d    = 1'b1;
                    end else begin
                        // An empty train reports completion in the very
                        // next cycle, which is the single FIN cycle.
                        state_d  = S_FIN;
                        phase_d  = '0;
                        remain_d = '0;
                        done_d   = 1'b1;
                    end
                end
            end
            S_HIGH: begin
                if (req.abort) begin
                    state_d  = S_IDLE;
                    phase_d  = '0;
                    remain_d = '0;
                end else if (phase_q != '0) begin
                    phase_d = phase_q - W_BITS'(1);
                    out_d   = 1'b1;
                end else if (remain_q != '0) begin
                    state_d = S_LOW;
                    phase_d = gap_q - W_BITS'(1);
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_LOW: begin
                if (req.abort) begin
                    state_d  = S_IDLE;
                    phase_d  = '0;
                    remain_d = '0;
                end else if (phase_q != '0) begin
                    phase_d = phase_q - W_BITS'(1);
                end else begin
                    state_d  = S_HIGH;
                    phase_d  = width_q - W_BITS'(1);
                    remain_d = remain_q - C_BITS'(1);
                    out_d    = 1'b1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; reset kills any train at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            phase_q  <= '0;
            remain_q <= '0;
            width_q  <= '0;
            gap_q    <= '0;
            out_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            remain_q <= remain_d;
            width_q  <= width_d;
            gap_q    <= gap_d;
            out_q    <= out_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_pulse_train_generator.sv
// Bench for pulse_train_generator: directed trains with hand-written
// per-cycle expectations of {out, done, busy, req_ready}.
module tb_pulse_train_generator;

  logic       clk;
  logic       rst_n;
  logic       out;
  logic       busy;
  logic       done;
  logic [1:0] dbg_state;

  pulse_train_generator_if #(.W_BITS(8), .C_BITS(8)) bus ();

  pulse_train_generator #(.W_BITS(8), .C_BITS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus),
    .out       (out),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: one entry per cycle, {out, done, busy, req_ready}
  logic [3:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int rises  = 0;
  logic out_prev = 1'b0;

  localparam logic [3:0] E_HIGH = 4'b1010;
  localparam logic [3:0] E_LOW  = 4'b0010;
  localparam logic [3:0] E_DONE = 4'b0101;
  localparam logic [3:0] E_IDLE = 4'b0001;

  // monitor: compare whenever an expectation is pending; count rising edges
  always @(negedge clk) begin
    logic [3:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({out, done, busy, bus.req_ready} !== e) begin
        errors++;
        $display("FAIL cycle_check t=%0t: out/done/busy/ready got %b expected %b",
                 $time, {out, done, busy, bus.req_ready}, e);
      end
    end
    if (out && !out_prev) rises++;
    out_prev = out;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver: present a request at negedge, release just after the accept edge
  task automatic send(input int w, input int g, input int c, input logic ab);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_width = 8'(w);
    bus.req_gap   = 8'(g);
    bus.req_count = 8'(c);
    bus.abort     = ab;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.abort     = 1'b0;
  endtask

  // push hand-written out pattern (MSB = first cycle), then the done cycle
  task automatic push_pattern(input logic [63:0] pat, input int len);
    for (int i = 0; i < len; i++)
      exp_q.push_back(pat[len-1-i] ? E_HIGH : E_LOW);
    exp_q.push_back(E_DONE);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d entries left, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] p;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_width = '0;
    bus.req_gap   = '0;
    bus.req_count = '0;
    bus.abort     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    // reset state
    repeat (2) exp_q.push_back(E_IDLE);
    wait_drain("reset_state");

    // W=1 G=2 C=3
    rises = 0;
    send(1, 2, 3, 1'b0);
    p = 64'b1001001;
    push_pattern(p, 7);
    wait_drain("w1g2c3");
    chk("w1g2c3_pulses", rises, 3);

    // W=3 G=0 C=2: gap 0 acts as 1
    rises = 0;
    send(3, 0, 2, 1'b0);
    p = 64'b1110111;
    push_pattern(p, 7);
    wait_drain("w3g0c2");
    chk("w3g0c2_pulses", rises, 2);

    // C=0 W=5: done in the cycle after accept, out stays low
    rises = 0;
    send(5, 1, 0, 1'b0);
    exp_q.push_back(4'b0110);
    exp_q.push_back(E_IDLE);
    exp_q.push_back(E_IDLE);
    wait_drain("c0");
    chk("c0_pulses", rises, 0);

    // W=0 G=0 C=1: one high cycle
    rises = 0;
    send(0, 0, 1, 1'b0);
    p = 64'b1;
    push_pattern(p, 1);
    wait_drain("w0c1");
    chk("w0c1_pulses", rises, 1);

    // back-to-back with req_valid held
    rises = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_width = 8'd1;
    bus.req_gap   = 8'd1;
    bus.req_count = 8'd1;
    @(posedge clk);
    #1;
    exp_q.push_back(E_HIGH);
    exp_q.push_back(E_DONE);
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    exp_q.push_back(E_HIGH);
    exp_q.push_back(E_DONE);
    exp_q.push_back(E_IDLE);
    wait_drain("b2b");
    chk("b2b_pulses", rises, 2);

    // abort in the 2nd high cycle of W=4 C=2
    rises = 0;
    send(4, 1, 2, 1'b0);
    exp_q.push_back(E_HIGH);
    exp_q.push_back(E_HIGH);
    repeat (3) exp_q.push_back(E_IDLE);
    @(posedge clk);
    #1;
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    wait_drain("abort");
    chk("abort_pulses", rises, 1);

    // accept and abort on the same edge: accept wins
    rises = 0;
    send(1, 1, 1, 1'b1);
    p = 64'b1;
    push_pattern(p, 1);
    wait_drain("accept_abort");
    chk("accept_abort_pulses", rises, 1);

    // W=255 C=1: 255 high cycles
    rises = 0;
    send(255, 1, 1, 1'b0);
    for (int i = 0; i < 255; i++) exp_q.push_back(E_HIGH);
    exp_q.push_back(E_DONE);
    wait_drain("w255");
    chk("w255_pulses", rises, 1);

    // async reset mid-HIGH
    send(10, 1, 1, 1'b0);
    repeat (3) exp_q.push_back(E_HIGH);
    wait_drain("pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_out_async", int'(out), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_ready", int'(bus.req_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) exp_q.push_back(E_IDLE);
    wait_drain("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
